// File: rtl/greyscale_loader.sv
// Streams a WIDTH x HEIGHT RGB444 frame from the image memory, converts it to
// greyscale and writes it linearly into the pyramid buffer as level 0.
module greyscale_loader #(
  parameter int WIDTH        = 128,
  parameter int HEIGHT       = 128,
  parameter int BIT_DEPTH    = 8,
  parameter int READ_LATENCY = 2,
  localparam int ADDR_W      = $clog2(WIDTH * HEIGHT)
) (
  input  logic                 clk_100mhz,
  input  logic                 sys_rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_W-1:0]    src_addr,
  input  logic [11:0]          src_data,
  output logic [ADDR_W-1:0]    dst_addr,
  output logic [BIT_DEPTH-1:0] dst_data,
  output logic                 dst_we
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [2:0]        DRAIN_LAST = 3'(READ_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t                   state;
  logic [2:0]               drain_cnt;
  logic [READ_LATENCY-1:0]  pipe_valid;
  logic [ADDR_W-1:0]        pipe_addr [READ_LATENCY];
  logic [7:0]               grey;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_100mhz or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      src_addr  <= '0;
      drain_cnt <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          src_addr  <= '0;
          drain_cnt <= '0;
          if (start) begin
            state <= READ;
            busy  <= 1'b1;
          end
        end
        READ: begin
          if (src_addr == LAST_ADDR) state <= DRAIN;
          else                       src_addr <= src_addr + ADDR_W'(1);
        end
        // Drain long enough for the last issued address to reach the output stage.
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the delayed addresses carry no reset; they are only consumed when
  // the matching pipe_valid bit (which is reset) says they are live.
  always_ff @(posedge clk_100mhz) begin
    pipe_addr[0] <= src_addr;
    for (int i = 1; i < READ_LATENCY; i++) pipe_addr[i] <= pipe_addr[i-1];
  end

  // grey = 4r + 8g + 4b, at most 240, so 8 bits never overflow.
  assign grey = {2'b00, src_data[11:8], 2'b00}
              + {1'b0,  src_data[7:4],  3'b000}
              + {2'b00, src_data[3:0],  2'b00};

  always_ff @(posedge clk_100mhz or posedge sys_rst) begin
    if (sys_rst) begin
      pipe_valid <= '0;
      dst_we     <= 1'b0;
      dst_addr   <= '0;
      dst_data   <= '0;
    end else begin
      pipe_valid[0] <= (state == READ);
      for (int i = 1; i < READ_LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
      dst_we <= pipe_valid[READ_LATENCY-1];
      if (pipe_valid[READ_LATENCY-1]) begin
        dst_addr <= pipe_addr[READ_LATENCY-1];
        dst_data <= BIT_DEPTH'(grey);
      end
    end
  end

endmodule

// File: tb/tb_greyscale_loader.sv
// Scoreboard bench for greyscale_loader: a default 128x128 instance for decode,
// restart and reset behaviour, plus small instances sweeping READ_LATENCY.
module tb_greyscale_loader;

  localparam int N0  = 128 * 128;
  localparam int RL0 = 2;
  localparam int AW0 = 14;

  localparam int SW_W  [4] = '{16, 16, 16, 4};
  localparam int SW_H  [4] = '{8, 8, 8, 2};
  localparam int SW_RL [4] = '{1, 3, 4, 2};

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  logic clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  int checks   = 0;
  int errors   = 0;
  int edge_cnt = 0;
  always @(posedge clk_100mhz) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int grey_ref(input int pix);
    int r, g, b;
    r = (pix >> 8) & 15;
    g = (pix >> 4) & 15;
    b = pix & 15;
    return 4 * r + 8 * g + 4 * b;
  endfunction

  // {cycle, address, data} packed so one comparison covers a whole write
  function automatic logic [63:0] pack_wr(input int cyc, input logic [15:0] addr,
                                          input logic [15:0] data);
    return {cyc, addr, data};
  endfunction

  // ---------------------------------------------------------------- default DUT
  logic           sys_rst, start, busy, done, dst_we;
  logic [AW0-1:0] src_addr, dst_addr;
  logic [11:0]    src_data;
  logic [7:0]     dst_data;
  logic [11:0]    mem0 [N0];
  logic [11:0]    rd0  [RL0];

  initial begin
    for (int a = 0; a < N0; a++) mem0[a] = 12'(a);
    mem0[0] = 12'h000;
    mem0[1] = 12'hFFF;
    mem0[2] = 12'hF00;
    mem0[3] = 12'h0F0;
    mem0[4] = 12'h00F;
    mem0[5] = 12'h123;
  end

  always @(posedge clk_100mhz) begin
    rd0[0] <= mem0[src_addr];
    for (int i = 1; i < RL0; i++) rd0[i] <= rd0[i-1];
  end
  assign src_data = rd0[RL0-1];

  greyscale_loader #(
    .WIDTH(128), .HEIGHT(128), .BIT_DEPTH(8), .READ_LATENCY(RL0)
  ) u_dut (
    .clk_100mhz(clk_100mhz),
    .sys_rst   (sys_rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .src_addr  (src_addr),
    .src_data  (src_data),
    .dst_addr  (dst_addr),
    .dst_data  (dst_data),
    .dst_we    (dst_we)
  );

  function automatic int exp_grey0(input int a);
    case (a)
      0:       return 0;
      1:       return 240;
      2:       return 60;
      3:       return 120;
      4:       return 60;
      5:       return 32;
      default: return grey_ref(a & 'hFFF);
    endcase
  endfunction

  wr_t q0[$];
  int  start_cnt0 = 0;
  int  exp_done0  = 0;
  int  wr_cnt0    = 0;
  int  done_cnt0  = 0;
  int  max_src0   = 0;

  always @(negedge clk_100mhz) begin : mon0
    int  cyc;
    wr_t e;
    cyc = edge_cnt - start_cnt0 + 1;
    if (sys_rst) begin
      check("quiet_in_reset", 64'({dst_we, done, busy}), 64'(0));
    end else begin
      if (int'(src_addr) > max_src0) max_src0 = int'(src_addr);
      if (dst_we) begin
        wr_cnt0++;
        if (q0.size() != 0) e = q0.pop_front();
        else                e = '{cyc: -1, addr: -1, data: -1};
        check("write", pack_wr(cyc, 16'(dst_addr), 16'(dst_data)),
              pack_wr(e.cyc, 16'(e.addr), 16'(e.data)));
      end
      if (done) begin
        done_cnt0++;
        check("done_cycle", 64'(cyc), 64'(exp_done0));
        check("busy_low_at_done", 64'(busy), 64'(0));
      end
    end
  end

  task automatic wait_cycle0(input int k);
    do @(negedge clk_100mhz); while (edge_cnt - start_cnt0 + 1 < k);
  endtask

  task automatic begin_frame0();
    @(negedge clk_100mhz);
    start = 1'b1;
    @(posedge clk_100mhz);
    #1;
    start      = 1'b0;
    start_cnt0 = edge_cnt;
    exp_done0  = N0 + RL0 + 3;
    wr_cnt0    = 0;
    done_cnt0  = 0;
    max_src0   = 0;
    q0         = {};
    for (int a = 0; a < N0; a++) q0.push_back('{cyc: a + 2 + RL0, addr: a, data: exp_grey0(a)});
  endtask

  task automatic pulse_at0(input int k);
    wait_cycle0(k);
    start = 1'b1;
    @(posedge clk_100mhz);
    #1;
    start = 1'b0;
  endtask

  task automatic end_frame0(input string tag);
    check({tag, "_write_count"}, 64'(wr_cnt0), 64'(N0));
    check({tag, "_done_count"}, 64'(done_cnt0), 64'(1));
    check({tag, "_queue_left"}, 64'(q0.size()), 64'(0));
    check({tag, "_max_src_addr"}, 64'(max_src0), 64'(N0 - 1));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_dst_we"}, 64'(dst_we), 64'(0));
    check({tag, "_src_addr"}, 64'(src_addr), 64'(0));
    check({tag, "_dst_addr"}, 64'(dst_addr), 64'(0));
    check({tag, "_dst_data"}, 64'(dst_data), 64'(0));
  endtask

  // ------------------------------------------------------- latency-sweep DUTs
  for (genvar gi = 0; gi < 4; gi++) begin : g_sw
    localparam int W  = SW_W[gi];
    localparam int H  = SW_H[gi];
    localparam int RL = SW_RL[gi];
    localparam int N  = W * H;
    localparam int AW = $clog2(N);

    logic          s_rst, s_start, s_busy, s_done, s_we;
    logic [AW-1:0] s_src_addr, s_dst_addr;
    logic [11:0]   s_src_data;
    logic [7:0]    s_dst_data;
    logic [11:0]   mem [N];
    logic [11:0]   rd  [RL];

    wr_t q[$];
    int  start_cnt = 0;
    int  wr_cnt    = 0;
    int  done_cnt  = 0;
    int  max_src   = 0;
    bit  active    = 1'b0;
    bit  fin       = 1'b0;

    initial for (int a = 0; a < N; a++) mem[a] = 12'((a * 37 + 5) & 'hFFF);

    always @(posedge clk_100mhz) begin
      rd[0] <= mem[s_src_addr];
      for (int i = 1; i < RL; i++) rd[i] <= rd[i-1];
    end
    assign s_src_data = rd[RL-1];

    greyscale_loader #(
      .WIDTH(W), .HEIGHT(H), .BIT_DEPTH(8), .READ_LATENCY(RL)
    ) u_dut (
      .clk_100mhz(clk_100mhz),
      .sys_rst   (s_rst),
      .start     (s_start),
      .busy      (s_busy),
      .done      (s_done),
      .src_addr  (s_src_addr),
      .src_data  (s_src_data),
      .dst_addr  (s_dst_addr),
      .dst_data  (s_dst_data),
      .dst_we    (s_we)
    );

    always @(negedge clk_100mhz) begin : mon
      int  cyc;
      wr_t e;
      if (active) begin
        cyc = edge_cnt - start_cnt + 1;
        if (int'(s_src_addr) > max_src) max_src = int'(s_src_addr);
        check($sformatf("rl%0d_%0dx%0d_busy_c%0d", RL, W, H, cyc), 64'(s_busy),
              64'(cyc >= 1 && cyc <= N + RL + 2));
        if (s_we) begin
          wr_cnt++;
          if (q.size() != 0) e = q.pop_front();
          else               e = '{cyc: -1, addr: -1, data: -1};
          check($sformatf("rl%0d_%0dx%0d_write", RL, W, H),
                pack_wr(cyc, 16'(s_dst_addr), 16'(s_dst_data)),
                pack_wr(e.cyc, 16'(e.addr), 16'(e.data)));
        end
        if (s_done) begin
          done_cnt++;
          check($sformatf("rl%0d_%0dx%0d_done_cycle", RL, W, H), 64'(cyc), 64'(N + RL + 3));
        end
      end
    end

    initial begin : stim
      s_rst   = 1'b1;
      s_start = 1'b0;
      repeat (3) @(negedge clk_100mhz);
      s_rst = 1'b0;
      repeat (2) @(negedge clk_100mhz);
      s_start = 1'b1;
      @(posedge clk_100mhz);
      #1;
      s_start   = 1'b0;
      start_cnt = edge_cnt;
      for (int a = 0; a < N; a++)
        q.push_back('{cyc: a + 2 + RL, addr: a, data: grey_ref((a * 37 + 5) & 'hFFF)});
      active = 1'b1;
      do @(negedge clk_100mhz); while (edge_cnt - start_cnt + 1 < N + RL + 4);
      #1;
      active = 1'b0;
      check($sformatf("rl%0d_%0dx%0d_write_count", RL, W, H), 64'(wr_cnt), 64'(N));
      check($sformatf("rl%0d_%0dx%0d_done_count", RL, W, H), 64'(done_cnt), 64'(1));
      check($sformatf("rl%0d_%0dx%0d_queue_left", RL, W, H), 64'(q.size()), 64'(0));
      check($sformatf("rl%0d_%0dx%0d_max_src_addr", RL, W, H), 64'(max_src), 64'(N - 1));
      fin = 1'b1;
    end
  end

  // ------------------------------------------------------------ main sequence
  initial begin : main_seq
    int t;
    sys_rst = 1'b1;
    start   = 1'b0;
    #1;
    check_outputs_zero("reset");
    repeat (3) @(negedge clk_100mhz);
    sys_rst = 1'b0;
    repeat (2) @(negedge clk_100mhz);

    // Frame A: colour decode, full frame, start pulses that must be ignored
    begin_frame0();
    check("a_busy_c1", 64'(busy), 64'(1));
    pulse_at0(1);
    pulse_at0(500);
    pulse_at0(N0 + RL0 + 3);
    end_frame0("a");

    // Frame B: started the cycle after A's done
    begin_frame0();
    wait_cycle0(N0 + RL0 + 2);
    check("b_busy_last_cycle", 64'(busy), 64'(1));
    wait_cycle0(N0 + RL0 + 4);
    #1;
    end_frame0("b");

    // Frame C: asynchronous reset mid-cycle at cycle 1000
    begin_frame0();
    wait_cycle0(1000);
    #2 sys_rst = 1'b1;
    #1;
    check_outputs_zero("midreset");
    repeat (3) @(negedge clk_100mhz);
    check("c_writes_before_reset", 64'(wr_cnt0), 64'(1000 - RL0 - 1));
    check("c_no_done", 64'(done_cnt0), 64'(0));
    sys_rst = 1'b0;

    // Frame D: restarts from address 0 after reset
    begin_frame0();
    wait_cycle0(N0 + RL0 + 4);
    #1;
    end_frame0("d");

    t = 0;
    while (!(g_sw[0].fin && g_sw[1].fin && g_sw[2].fin && g_sw[3].fin) && t < 2000) begin
      @(negedge clk_100mhz);
      t++;
    end
    check("sweep_finished",
          64'({g_sw[3].fin, g_sw[2].fin, g_sw[1].fin, g_sw[0].fin}), 64'(4'hF));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/greyscale_loader.md
# greyscale_loader

Streams a WIDTH×HEIGHT RGB444 frame out of the image memory, converts each pixel to BIT_DEPTH-bit greyscale, and writes it linearly into port A of the Gaussian pyramid buffer as pyramid level 0. It sits between the UART-loaded image memory and the pyramid buffer. It is started by a one-cycle `start` pulse and signals completion with `done`. It hides the source memory's fixed read latency with a matched address/valid pipeline.

## Interface
- WIDTH, 128: frame width in pixels.
- HEIGHT, 128: frame height in pixels.
- BIT_DEPTH, 8: greyscale output width; must be ≥ 8.
- READ_LATENCY, 2: cycles from `src_addr` presented to `src_data` valid; legal values are 1 to 4.

- clk_100mhz  input  1  system clock, all logic on its rising edge.
- sys_rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle request to convert a frame; honoured only in IDLE.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse after the last write.
- src_addr  output  $clog2(WIDTH*HEIGHT)  image memory read address.
- src_data  input  12  RGB444 pixel, {r[11:8], g[7:4], b[3:0]}.
- dst_addr  output  $clog2(WIDTH*HEIGHT)  pyramid buffer write address.
- dst_data  output  BIT_DEPTH  greyscale pixel.
- dst_we  output  1  pyramid buffer write enable.

## Operation
- FSM states:
  - IDLE:
    - `start` → READ.
    - Clear `src_addr`.
  - READ:
    - Present one address per cycle.
    - After issuing address WIDTH*HEIGHT−1 → DRAIN.
  - DRAIN:
    - Count READ_LATENCY+1 cycles.
    - Every write still in the pipeline completes.
    - Then → DONE.
  - DONE:
    - `done`=1 for one cycle.
    - → IDLE.
- Address counter:
  - Counts from 0 to WIDTH*HEIGHT−1 with no gaps.
  - Never presents WIDTH*HEIGHT.
  - Holds its value outside READ.
- Valid/address shift register:
  - Depth READ_LATENCY.
  - A `1` enters with each address issued in READ.
  - The delayed address pairs with `src_data` when it arrives.
- Conversion:
  - grey = 4·r + 8·g + 4·b, computed at 8 bits, range 0 to 240.
  - No saturation is needed.
  - The result is zero-extended to BIT_DEPTH.
- Output stage is registered:
  - `dst_addr` is the delayed address.
  - `dst_data` is grey.
  - `dst_we` is the delayed valid.
- Outputs during IDLE and DONE:
  - `dst_we`=0.
  - `dst_addr` and `dst_data` hold their last values.
- `start` while `busy` or in DONE: ignored, no restart, no queueing.
- Reset mid-frame:
  - All state and outputs go to reset values immediately.
  - No further `dst_we`.
  - No `done`.
  - The next `start` begins again at address 0.
- Reset values:
  - FSM = IDLE.
  - busy=0, done=0, dst_we=0.
  - src_addr=0, dst_addr=0, dst_data=0.
  - Pipeline valids=0.

## Timing
- `start` is sampled high at edge E0. Cycle k means the cycle after edge E(k−1).
- Reads: `src_addr`=k−1 in cycle k, for k=1 to N, where N=WIDTH*HEIGHT.
- Source data: `src_data` for address a is valid in cycle a+1+READ_LATENCY.
- Writes: `dst_we`=1 with `dst_addr`=a in cycle a+2+READ_LATENCY.
  - Exactly N write cycles, contiguous, in ascending address order.
  - No duplicate writes.
- Latency from `src_addr` to `dst_we` is READ_LATENCY+1 cycles.
- `busy`: high in cycles 1 to N+READ_LATENCY+2.
- `done`: high only in cycle N+READ_LATENCY+3, while `busy` is low.
- Frame time: a new `start` accepted in cycle N+READ_LATENCY+4 produces its first read in the following cycle.
- Throughput: 1 pixel/cycle. Default frame is 16384 writes in 16389 cycles from `start` to `done`.

## Test plan
- Colour decode:
  - Load image memory with a pattern: addr0=12'h000, addr1=12'hFFF, addr2=12'hF00, addr3=12'h0F0, addr4=12'h00F, addr5=12'h123; pulse `start`.
  - Required writes: addr0→0, 1→240, 2→60, 3→120, 4→60, 5→32.
- Full frame, default parameters:
  - Fill memory with value = addr[11:0]; pulse `start`.
  - Required: exactly 16384 `dst_we` cycles, addresses 0 to 16383 contiguous, every dst_data equal to the reference model.
  - Required: `done` in cycle 16389 after the `start` edge.
  - Required: `src_addr` never exceeds 16383.
- Latency sweep:
  - Repeat the full-frame test with READ_LATENCY=1, 3, 4, using a matching memory model.
  - Required: first `dst_we` in cycle READ_LATENCY+2, data correct.
- Start while busy:
  - Pulse `start` in cycles 1, 500 and N+READ_LATENCY+3 of a frame.
  - Required: no restart, one `done`, N writes.
  - Required: a `start` one cycle after `done` runs a second frame.
- Reset mid-frame:
  - Assert `sys_rst` asynchronously mid-cycle at cycle 1000.
  - Required: all outputs 0 immediately, no `done`, no writes while reset is held.
  - After release plus `start`: writes begin at addr 0 and the frame completes correctly.
- Small frame:
  - WIDTH=4, HEIGHT=2, READ_LATENCY=2.
  - Required: 8 writes at cycles 4 to 11, `done` at cycle 13, `busy` high in cycles 1 to 12.
